// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and helpers for the ALU command driver
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_LSH = 3'b101;
    localparam logic [2:0] OP_RSH = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } drv_state_t;

    // Shifters and the multiplier are the units that need an alu_inp start pulse
    function automatic logic is_seq_op(input logic [2:0] op);
        return (op == OP_LSH) || (op == OP_RSH) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_cmd_driver_if.sv
// rtl/alu_cmd_driver_if.sv - command/response handshake bundle of the ALU command driver
interface alu_cmd_driver_if #(
    parameter int N = 8
) ();
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_y;
    logic [N-1:0] rsp_y_ext;
    logic         rsp_flg;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_y, rsp_y_ext, rsp_flg
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_y, rsp_y_ext, rsp_flg
    );
endinterface

// File: rtl/alu_drv_timer.sv
// rtl/alu_drv_timer.sv - loadable down-counter with zero flag for ALU result latency
module alu_drv_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load wins over decrement; decrement stops at zero
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);
endmodule

// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - single-outstanding command initiator for the 8-op ALU; ALU_DRV_FLGCNT_EN adds flg_cnt
module alu_cmd_driver #(
    parameter int N         = 8,
    parameter int SHIFT_LAT = 1,
    parameter int MUL_LAT   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_cmd_driver_if.slave      bus,
    output logic [2:0]           alu_op,
    output logic [N-1:0]         alu_a,
    output logic [N-1:0]         alu_b,
    output logic                 alu_inp,
    input  logic [N-1:0]         alu_y,
    input  logic [N-1:0]         alu_y_ext,
    input  logic                 alu_flg,
    output logic                 busy
`ifdef ALU_DRV_FLGCNT_EN
   ,output logic [7:0]           flg_cnt
`endif
);
    import alu_pkg::*;

    localparam int MAX_LAT = (SHIFT_LAT > MUL_LAT) ? SHIFT_LAT : MUL_LAT;
    localparam int TW      = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;

    drv_state_t   state_q, state_d;
    logic [2:0]   alu_op_q, alu_op_d;
    logic [N-1:0] alu_a_q, alu_a_d;
    logic [N-1:0] alu_b_q, alu_b_d;
    logic [N-1:0] rsp_y_q, rsp_y_d;
    logic [N-1:0] rsp_y_ext_q, rsp_y_ext_d;
    logic         rsp_flg_q, rsp_flg_d;
    logic         tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0] lat_val;

    alu_drv_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (lat_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Per-class wait time for the operation currently held on the ALU inputs
    always_comb begin
        lat_val = '0;
        if ((alu_op_q == OP_LSH) || (alu_op_q == OP_RSH)) begin
            lat_val = TW'(SHIFT_LAT);
        end else if (alu_op_q == OP_MUL) begin
            lat_val = TW'(MUL_LAT);
        end
    end

    // Next-state, operand latch and masked result capture
    always_comb begin
        state_d     = state_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_y_d     = rsp_y_q;
        rsp_y_ext_d = rsp_y_ext_q;
        rsp_flg_d   = rsp_flg_q;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    alu_op_d = bus.cmd_op;
                    alu_a_d  = bus.cmd_a;
                    alu_b_d  = bus.cmd_b;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                tmr_load = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (tmr_zero) begin
                    // Only forward the fields the ALU defines for this op
                    rsp_y_d     = alu_y;
                    rsp_y_ext_d = (alu_op_q == OP_MUL) ? alu_y_ext : '0;
                    rsp_flg_d   = ((alu_op_q == OP_ADD) || (alu_op_q == OP_SUB)) ? alu_flg : 1'b0;
                    state_d     = ST_RESP;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_y_q     <= '0;
            rsp_y_ext_q <= '0;
            rsp_flg_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_y_q     <= rsp_y_d;
            rsp_y_ext_q <= rsp_y_ext_d;
            rsp_flg_q   <= rsp_flg_d;
        end
    end

`ifdef ALU_DRV_FLGCNT_EN
    logic [7:0] flg_cnt_q, flg_cnt_d;

    // Saturating count of flagged responses actually handed off
    always_comb begin
        flg_cnt_d = flg_cnt_q;
        if ((state_q == ST_RESP) && bus.rsp_ready && rsp_flg_q && (flg_cnt_q != 8'hFF)) begin
            flg_cnt_d = flg_cnt_q + 8'd1;
        end
    end

    // Flag counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flg_cnt_q <= '0;
        end else begin
            flg_cnt_q <= flg_cnt_d;
        end
    end

    assign flg_cnt = flg_cnt_q;
`endif

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_y_ext = rsp_y_ext_q;
    assign bus.rsp_flg   = rsp_flg_q;
    assign alu_op        = alu_op_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_inp       = (state_q == ST_EXEC) && is_seq_op(alu_op_q);
    assign busy          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb/tb_alu_cmd_driver.sv - self-checking bench for alu_cmd_driver with a behavioural ALU
module tb_alu_cmd_driver;
    import alu_pkg::*;

    localparam int N         = 8;
    localparam int SHIFT_LAT = 1;
    localparam int MUL_LAT   = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   alu_op;
    logic [N-1:0] alu_a, alu_b;
    logic         alu_inp;
    logic [N-1:0] alu_y, alu_y_ext;
    logic         alu_flg;
    logic         busy;
`ifdef ALU_DRV_FLGCNT_EN
    logic [7:0]   flg_cnt;
`endif

    int errors = 0;
    int checks = 0;

    alu_cmd_driver_if #(.N(N)) bus ();

    alu_cmd_driver #(.N(N), .SHIFT_LAT(SHIFT_LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_inp   (alu_inp),
        .alu_y     (alu_y),
        .alu_y_ext (alu_y_ext),
        .alu_flg   (alu_flg),
        .busy      (busy)
`ifdef ALU_DRV_FLGCNT_EN
       ,.flg_cnt   (flg_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference arithmetic: {y_ext, y, flg} with undefined fields reported as 0
    function automatic logic [16:0] ref_calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  s;
        logic [15:0] p;
        case (op)
            OP_ADD: begin s = {1'b0, a} + {1'b0, b}; return {8'h00, s[7:0], s[8]}; end
            OP_SUB: begin s = {1'b0, a} - {1'b0, b}; return {8'h00, s[7:0], (a < b)}; end
            OP_AND: return {8'h00, a & b, 1'b0};
            OP_OR:  return {8'h00, a | b, 1'b0};
            OP_NOT: return {8'h00, ~a, 1'b0};
            OP_LSH: return {8'h00, a << b[2:0], 1'b0};
            OP_RSH: return {8'h00, a >> b[2:0], 1'b0};
            default: begin p = a * b; return {p, 1'b0}; end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op);
        if (op == OP_LSH || op == OP_RSH) return 3 + SHIFT_LAT;
        if (op == OP_MUL) return 3 + MUL_LAT;
        return 3;
    endfunction

    // Behavioural ALU: sequential results are garbage until their latency after alu_inp has elapsed
    int since = 0;
    int inp_total = 0;
    always @(posedge clk) begin
        if (alu_inp) since = 0;
        else if (since < 1000) since = since + 1;
    end
    always @(negedge clk) if (alu_inp) inp_total = inp_total + 1;

    always_comb begin
        logic [16:0] r;
        logic        ok;
        r  = ref_calc(alu_op, alu_a, alu_b);
        ok = !is_seq_op(alu_op) || (since >= ((alu_op == OP_MUL) ? MUL_LAT : SHIFT_LAT));
        alu_y     = ok ? r[8:1] : 8'hA5;
        alu_y_ext = (alu_op == OP_MUL && ok) ? r[16:9] : 8'h5A;
        alu_flg   = (alu_op == OP_ADD || alu_op == OP_SUB) ? r[0] : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command, measure accept-to-rsp_valid edges, hold rsp_ready low for 'hold' cycles, hand off
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int hold,
                           output int lat, output logic [7:0] y, output logic [7:0] yext,
                           output logic flg, output logic stable, output int pulses);
        int guard;
        int inp0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
        guard = 0;
        while (!bus.cmd_ready && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) check("accept_timeout", 32'(guard), 32'd0);
        inp0 = inp_total;
        @(posedge clk);
        lat = 1;
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        while (!bus.rsp_valid && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
        y = bus.rsp_y; yext = bus.rsp_y_ext; flg = bus.rsp_flg;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.cmd_ready || !busy || bus.rsp_y !== y ||
                bus.rsp_y_ext !== yext || bus.rsp_flg !== flg || alu_op !== op) stable = 1'b0;
        end
        pulses = inp_total - inp0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         hold;
        logic [7:0] y;
        logic [7:0] yext;
        logic       flg;
        int         lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int lat, pulses, guard;
        logic [7:0] y, yext;
        logic flg, stable, ok, seen;
        logic [16:0] r;
        logic [2:0] rop;
        logic [7:0] ra, rb;

        vecs[0] = '{OP_ADD, 8'h7F, 8'h01, 0, 8'h80, 8'h00, 1'b0, 3};
        vecs[1] = '{OP_MUL, 8'h10, 8'h10, 0, 8'h00, 8'h01, 1'b0, 11};
        vecs[2] = '{OP_AND, 8'hF0, 8'h3C, 5, 8'h30, 8'h00, 1'b0, 3};
        vecs[3] = '{OP_SUB, 8'h05, 8'h07, 1, 8'hFE, 8'h00, 1'b1, 3};
        vecs[4] = '{OP_NOT, 8'h0F, 8'hAA, 0, 8'hF0, 8'h00, 1'b0, 3};
        vecs[5] = '{OP_LSH, 8'h81, 8'h01, 0, 8'h02, 8'h00, 1'b0, 4};
        vecs[6] = '{OP_RSH, 8'h81, 8'h03, 2, 8'h10, 8'h00, 1'b0, 4};
        vecs[7] = '{OP_ADD, 8'hFF, 8'h01, 0, 8'h00, 8'h00, 1'b1, 3};
        vecs[8] = '{OP_OR,  8'h50, 8'h05, 0, 8'h55, 8'h00, 1'b0, 3};
        vecs[9] = '{OP_MUL, 8'hFF, 8'hFF, 3, 8'h01, 8'hFE, 1'b0, 11};

        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0; bus.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_alu_inp", 32'(alu_inp), 32'd0);
        check("reset_alu_regs", {8'h00, alu_op, alu_a, alu_b}, 32'd0);
        check("reset_rsp_regs", {15'h0, bus.rsp_y, bus.rsp_y_ext, bus.rsp_flg}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold, lat, y, yext, flg, stable, pulses);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].y));
            check($sformatf("vec%0d_yext", i), 32'(yext), 32'(vecs[i].yext));
            check($sformatf("vec%0d_flg", i), 32'(flg), 32'(vecs[i].flg));
            check($sformatf("vec%0d_inp_pulses", i), 32'(pulses), is_seq_op(vecs[i].op) ? 32'd1 : 32'd0);
            if (vecs[i].hold > 0) check($sformatf("vec%0d_hold_stable", i), 32'(stable), 32'd1);
        end
        @(negedge clk);
        check("idle_after_hold", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7)); ra = 8'($urandom); rb = 8'($urandom);
            r = ref_calc(rop, ra, rb);
            run_cmd(rop, ra, rb, int'($urandom_range(0, 2)), lat, y, yext, flg, stable, pulses);
            check($sformatf("rnd%0d_op%0d_lat", i, rop), 32'(lat), 32'(ref_lat(rop)));
            check($sformatf("rnd%0d_op%0d_res", i, rop), {15'h0, yext, y, flg}, {15'h0, r});
            check($sformatf("rnd%0d_stable", i), 32'(stable), 32'd1);
        end

        // A command held valid during a mul is only taken after the mul response is handed off
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_MUL; bus.cmd_a = 8'h03; bus.cmd_b = 8'h04;
        @(posedge clk);
        #1 bus.cmd_op = OP_ADD; bus.cmd_a = 8'h01; bus.cmd_b = 8'h02;
        ok = 1'b1; guard = 0;
        @(negedge clk);
        while (!bus.rsp_valid && guard < 30) begin
            if (bus.cmd_ready || alu_op !== OP_MUL || alu_a !== 8'h03) ok = 1'b0;
            @(negedge clk); guard++;
        end
        check("busy_blocks_cmd", 32'(ok), 32'd1);
        check("busy_mul_y", {16'h0, bus.rsp_y_ext, bus.rsp_y}, 32'h000C);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        check("ready_after_handoff", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("next_accepted_op", {29'h0, alu_op}, {29'h0, OP_ADD});
        check("next_accepted_busy", 32'(busy), 32'd1);
        guard = 0;
        while (!bus.rsp_valid && guard < 30) begin @(negedge clk); guard++; end
        check("next_add_y", 32'(bus.rsp_y), 32'h03);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;

        // Reset four cycles into a mul drops it at once
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_MUL; bus.cmd_a = 8'h22; bus.cmd_b = 8'h33;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_alu_inp", 32'(alu_inp), 32'd0);
        check("rst_alu_op", {29'h0, alu_op}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (bus.rsp_valid || busy) seen = 1'b1; end
        check("rst_no_response", 32'(seen), 32'd0);

`ifdef ALU_DRV_FLGCNT_EN
        check("flgcnt_after_reset", 32'(flg_cnt), 32'd0);
        for (int i = 0; i < 300; i++) begin
            run_cmd(OP_ADD, 8'hFF, 8'h01, 0, lat, y, yext, flg, stable, pulses);
            if (i == 43) begin
                @(negedge clk);
                check("flgcnt_44", 32'(flg_cnt), 32'd44);
            end
        end
        @(negedge clk);
        check("flgcnt_saturated", 32'(flg_cnt), 32'hFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
